// File: rtl/hud_pip_renderer.sv
// HUD pip renderer: draws health and block pips for two players along the bottom HUD strip,
// with frame-synchronised inputs and a blinking flash on each heart that was just lost.
module hud_pip_renderer #(
    parameter int NUM_PIPS     = 3,
    parameter int PIP_W        = 40,
    parameter int PIP_GAP      = 20,
    parameter int HEART_Y      = 410,
    parameter int HEART_H      = 40,
    parameter int BLOCK_Y      = 460,
    parameter int BLOCK_H      = 10,
    parameter int P1_X0        = 100,
    parameter int P2_X0        = 380,
    parameter int FLASH_FRAMES = 16,
    parameter int BLINK_BIT    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [9:0]          x,
    input  logic [9:0]          y,
    input  logic [NUM_PIPS-1:0] p1_health,
    input  logic [NUM_PIPS-1:0] p1_block,
    input  logic [NUM_PIPS-1:0] p2_health,
    input  logic [NUM_PIPS-1:0] p2_block,
    output logic                active,
    output logic [7:0]          pixel_color
);

    localparam logic [9:0] HeartTop = 10'(HEART_Y);
    localparam logic [9:0] HeartBot = 10'(HEART_Y + HEART_H);
    localparam logic [9:0] BlockTop = 10'(BLOCK_Y);
    localparam logic [9:0] BlockBot = 10'(BLOCK_Y + BLOCK_H);
    localparam logic [9:0] PipWidth = 10'(PIP_W);

    logic                origin;
    logic                origin_q;
    logic                frame_tick;
    logic [NUM_PIPS-1:0] p1_health_q, p1_block_q, p2_health_q, p2_block_q;
    logic [7:0]          p1_cnt_q [NUM_PIPS];
    logic [7:0]          p1_cnt_d [NUM_PIPS];
    logic [7:0]          p2_cnt_q [NUM_PIPS];
    logic [7:0]          p2_cnt_d [NUM_PIPS];
    logic                active_d, active_q;
    logic [7:0]          color_d, color_q;
    logic                in_heart, in_block;

    assign origin     = (x == 10'd0) && (y == 10'd0);
    assign frame_tick = origin && !origin_q;

    function automatic logic [9:0] pip_left(input int base, input int idx);
        return 10'(base + idx * (PIP_W + PIP_GAP));
    endfunction

    // Old shadow vs. freshly sampled bit decides load / clear / count down.
    function automatic logic [7:0] next_cnt(input logic old_bit, input logic new_bit,
                                            input logic [7:0] cnt);
        if (old_bit && !new_bit) return 8'(FLASH_FRAMES);
        if (!old_bit && new_bit) return 8'd0;
        if (cnt != 8'd0)         return cnt - 8'd1;
        return cnt;
    endfunction

    function automatic logic [7:0] heart_color(input logic bit_q, input logic [7:0] cnt);
        if (bit_q)         return 8'hE0;
        if (cnt == 8'd0)   return 8'h00;
        return cnt[BLINK_BIT] ? 8'hFF : 8'hE0;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_PIPS; i++) begin
            p1_cnt_d[i] = p1_cnt_q[i];
            p2_cnt_d[i] = p2_cnt_q[i];
            if (frame_tick) begin
                p1_cnt_d[i] = next_cnt(p1_health_q[i], p1_health[i], p1_cnt_q[i]);
                p2_cnt_d[i] = next_cnt(p2_health_q[i], p2_health[i], p2_cnt_q[i]);
            end
        end
    end

    always_comb begin
        active_d = 1'b0;
        color_d  = 8'h00;
        in_heart = (y >= HeartTop) && (y < HeartBot);
        in_block = (y >= BlockTop) && (y < BlockBot);
        for (int i = 0; i < NUM_PIPS; i++) begin
            if (x >= pip_left(P1_X0, i) && x < pip_left(P1_X0, i) + PipWidth) begin
                if (in_heart) begin
                    active_d = 1'b1;
                    color_d  = heart_color(p1_health_q[i], p1_cnt_q[i]);
                end else if (in_block) begin
                    active_d = 1'b1;
                    color_d  = p1_block_q[i] ? 8'h03 : 8'hFF;
                end
            end
            // Player 2 is mirrored: its bit 0 is the rightmost pip.
            if (x >= pip_left(P2_X0, i) && x < pip_left(P2_X0, i) + PipWidth) begin
                if (in_heart) begin
                    active_d = 1'b1;
                    color_d  = heart_color(p2_health_q[NUM_PIPS-1-i], p2_cnt_q[NUM_PIPS-1-i]);
                end else if (in_block) begin
                    active_d = 1'b1;
                    color_d  = p2_block_q[NUM_PIPS-1-i] ? 8'h03 : 8'hFF;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            origin_q    <= 1'b0;
            p1_health_q <= '0;
            p1_block_q  <= '0;
            p2_health_q <= '0;
            p2_block_q  <= '0;
            for (int i = 0; i < NUM_PIPS; i++) begin
                p1_cnt_q[i] <= 8'd0;
                p2_cnt_q[i] <= 8'd0;
            end
            active_q    <= 1'b0;
            color_q     <= 8'h00;
        end else begin
            origin_q <= origin;
            if (frame_tick) begin
                p1_health_q <= p1_health;
                p1_block_q  <= p1_block;
                p2_health_q <= p2_health;
                p2_block_q  <= p2_block;
            end
            for (int i = 0; i < NUM_PIPS; i++) begin
                p1_cnt_q[i] <= p1_cnt_d[i];
                p2_cnt_q[i] <= p2_cnt_d[i];
            end
            active_q <= active_d;
            color_q  <= color_d;
        end
    end

    assign active      = active_q;
    assign pixel_color = color_q;

endmodule
